mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates a single shared memory port between a fetch requester
//   (read-only) and a data requester (read/write). One access at a time
//   moves through IDLE -> ACCESS -> RESP. Every output is registered.
//
//   Optional feature: define ARB_RR_EN for round-robin tie breaking.
//   Without it, data always wins a tie.
//
// Parameters
//   TIMEOUT  cycles allowed in ACCESS waiting for MemReady (1..255)
//   AW       address width (data width is fixed at 16)
//
// Ports
//   CLK, Reset                  clock, synchronous active-high reset
//   FReq, FAddr                 fetch request/address (held until FDone)
//   DReq, DWe, DAddr, DWData    data request/write-enable/address/wdata
//   FGnt, DGnt                  high while that requester owns the port
//   FDone, DDone                one-cycle completion pulse
//   FRData, DRData              last read data returned to each side
//   Err                         timeout flag, meaningful only with a Done
//   MemAddr, MemWData           shared port address/write data
//   MemRead, MemWrite           shared port strobes
//   MemRData, MemReady          memory response
module mem_port_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int AW      = 16
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          FReq,
  input  logic [AW-1:0] FAddr,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [15:0]   DWData,
  output logic          FGnt,
  output logic          DGnt,
  output logic          FDone,
  output logic          DDone,
  output logic [15:0]   FRData,
  output logic [15:0]   DRData,
  output logic          Err,
  output logic [AW-1:0] MemAddr,
  output logic [15:0]   MemWData,
  output logic          MemRead,
  output logic          MemWrite,
  input  logic [15:0]   MemRData,
  input  logic          MemReady
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [7:0]    wcnt_inc;
  logic          sel_data_q, sel_data_d;   // 1 = data side owns the access
  logic          we_q, we_d;
  logic          tie_to_data;
  logic          pick_data;

  logic          fgnt_d, dgnt_d, fdone_d, ddone_d, err_d, rd_d, wr_d;
  logic [15:0]   frdata_d, drdata_d, wdata_d;
  logic [AW-1:0] addr_d;

  assign wcnt_inc = wcnt_q + 8'd1;

`ifdef ARB_RR_EN
  // Remembers who was granted last; a tie goes to the other side.
  logic last_fetch_q, last_fetch_d;
  assign tie_to_data = last_fetch_q;
`else
  assign tie_to_data = 1'b1;
`endif

  assign pick_data = DReq & (~FReq | tie_to_data);

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    sel_data_d = sel_data_q;
    we_d       = we_q;
    addr_d     = MemAddr;
    wdata_d    = MemWData;
    frdata_d   = FRData;
    drdata_d   = DRData;
    fgnt_d     = 1'b0;
    dgnt_d     = 1'b0;
    fdone_d    = 1'b0;
    ddone_d    = 1'b0;
    err_d      = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
`ifdef ARB_RR_EN
    last_fetch_d = last_fetch_q;
`endif
    case (state_q)
      IDLE: begin
        if (FReq || DReq) begin
          // Owner's request fields are latched here; the port registers
          // themselves hold them for the whole access.
          sel_data_d = pick_data;
          we_d       = pick_data & DWe;
          addr_d     = pick_data ? DAddr : FAddr;
          if (pick_data) wdata_d = DWData;
          wcnt_d     = 8'd0;
          state_d    = ACCESS;
          fgnt_d     = ~pick_data;
          dgnt_d     = pick_data;
          rd_d       = ~(pick_data & DWe);
          wr_d       = pick_data & DWe;
`ifdef ARB_RR_EN
          last_fetch_d = ~pick_data;
`endif
        end
      end
      ACCESS: begin
        if (MemReady) begin
          state_d = RESP;
          fdone_d = ~sel_data_q;
          ddone_d = sel_data_q;
          if (!we_q) begin
            if (sel_data_q) drdata_d = MemRData;
            else            frdata_d = MemRData;
          end
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == 8'(TIMEOUT)) begin
            // Abort: complete with Err, read data left untouched.
            state_d = RESP;
            fdone_d = ~sel_data_q;
            ddone_d = sel_data_q;
            err_d   = 1'b1;
          end else begin
            fgnt_d = ~sel_data_q;
            dgnt_d = sel_data_q;
            rd_d   = ~we_q;
            wr_d   = we_q;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      wcnt_q     <= 8'd0;
      sel_data_q <= 1'b0;
      we_q       <= 1'b0;
      FGnt       <= 1'b0;
      DGnt       <= 1'b0;
      FDone      <= 1'b0;
      DDone      <= 1'b0;
      Err        <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      FRData     <= 16'd0;
      DRData     <= 16'd0;
      MemAddr    <= '0;
      MemWData   <= 16'd0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      sel_data_q <= sel_data_d;
      we_q       <= we_d;
      FGnt       <= fgnt_d;
      DGnt       <= dgnt_d;
      FDone      <= fdone_d;
      DDone      <= ddone_d;
      Err        <= err_d;
      MemRead    <= rd_d;
      MemWrite   <= wr_d;
      FRData     <= frdata_d;
      DRData     <= drdata_d;
      MemAddr    <= addr_d;
      MemWData   <= wdata_d;
    end
  end

`ifdef ARB_RR_EN
  // Reset leaves the pointer at "fetch served last" so data wins first tie.
  always_ff @(posedge CLK) begin
    if (Reset) last_fetch_q <= 1'b1;
    else       last_fetch_q <= last_fetch_d;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of directed accesses, a reset
// abort sequence, and randomized accesses predicted by a transaction-level
// model (winner, grant length, error and returned data).
module tb_mem_port_arbiter;

  localparam int TO = 15;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset, FReq, DReq, DWe, MemReady;
  logic [15:0] FAddr, DAddr, DWData, MemRData;
  logic        FGnt, DGnt, FDone, DDone, Err, MemRead, MemWrite;
  logic [15:0] FRData, DRData, MemAddr, MemWData;

  mem_port_arbiter #(.TIMEOUT(TO), .AW(16)) dut (
    .CLK(CLK), .Reset(Reset), .FReq(FReq), .FAddr(FAddr), .DReq(DReq),
    .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .FGnt(FGnt), .DGnt(DGnt),
    .FDone(FDone), .DDone(DDone), .FRData(FRData), .DRData(DRData),
    .Err(Err), .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemRData(MemRData), .MemReady(MemReady)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Model state: last data returned to each side, and who was served last.
  logic [15:0] m_frd, m_drd;
  bit          m_last_f;

  typedef struct {
    bit          freq, dreq, dwe;
    logic [15:0] fa, da, wd, rd;
    int          waits;
    bit          exp_d;
    int          exp_cyc;
    bit          exp_err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one access. The bench plays the memory: MemReady rises on grant
  // cycle number 'waits' (0-based). Expected owner/length/err come in.
  task automatic do_access(input bit freq, input bit dreq, input bit dwe,
                           input logic [15:0] fa, input logic [15:0] da,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input int waits, input bit drop_early,
                           input bit exp_d, input int exp_cyc, input bit exp_err);
    int          gcnt;
    bit          done;
    bit          exp_we;
    logic [15:0] exp_addr;
    exp_we   = exp_d & dwe;
    exp_addr = exp_d ? da : fa;
    FReq = freq; DReq = dreq; DWe = dwe; FAddr = fa; DAddr = da;
    DWData = wd; MemRData = rd; MemReady = 1'b0;
    gcnt = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge CLK); #1;
      if (FGnt || DGnt) begin
        chk("gnt_owner", 32'({FGnt, DGnt}), 32'(exp_d ? 2'b01 : 2'b10));
        chk("mem_addr", 32'(MemAddr), 32'(exp_addr));
        chk("mem_strobes", 32'({MemRead, MemWrite}), 32'(exp_we ? 2'b01 : 2'b10));
        if (exp_we) chk("mem_wdata", 32'(MemWData), 32'(wd));
        MemReady = (gcnt == waits);
        gcnt++;
        if (drop_early) begin
          if (exp_d) DReq = 1'b0;
          else       FReq = 1'b0;
        end
      end else begin
        MemReady = 1'b0;
      end
      if (FDone || DDone) begin
        done = 1'b1;
        chk("done_owner", 32'({FDone, DDone}), 32'(exp_d ? 2'b01 : 2'b10));
        chk("gnt_cycles", 32'(gcnt), 32'(exp_cyc));
        chk("err", 32'(Err), 32'(exp_err));
        chk("resp_quiet", 32'({FGnt, DGnt, MemRead, MemWrite}), 32'd0);
        if (!exp_we && !exp_err) begin
          if (exp_d) m_drd = rd;
          else       m_frd = rd;
        end
        chk("frdata", 32'(FRData), 32'(m_frd));
        chk("drdata", 32'(DRData), 32'(m_drd));
        if (exp_d) DReq = 1'b0;
        else       FReq = 1'b0;
        MemReady = 1'b0;
      end
    end
    if (!done) chk("done_seen", 32'd0, 32'd1);
    m_last_f = ~exp_d;
    @(posedge CLK); #1;
    chk("done_pulse", 32'({FDone, DDone, FGnt, DGnt, MemRead, MemWrite}), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit fq, dq, we, de, ed;
    int w, ecyc;

    Reset = 1'b1; FReq = 1'b0; DReq = 1'b0; DWe = 1'b0; MemReady = 1'b0;
    FAddr = 16'h0; DAddr = 16'h0; DWData = 16'h0; MemRData = 16'h0;
    m_frd = 16'h0; m_drd = 16'h0; m_last_f = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
    chk("reset_ctrl", 32'({FGnt, DGnt, FDone, DDone, Err, MemRead, MemWrite}), 32'd0);
    chk("reset_rdata", 32'({FRData, DRData}), 32'd0);
    chk("reset_port", 32'({MemAddr, MemWData}), 32'd0);

    // Ties first (round-robin pointer fresh from reset), then singles.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200, 16'h0000, 16'h1111, 0, 1'b1, 1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0101, 16'h0201, 16'h0000, 16'h2222, 0, ~RR, 1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0102, 16'h0202, 16'h0000, 16'h3333, 0, 1'b1, 1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'h0103, 16'h0203, 16'h0000, 16'h4444, 0, ~RR, 1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 0, 1'b0, 1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200, 16'h1234, 16'hDEAD, 3, 1'b1, 4, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0300, 16'h0000, 16'h5A5A, 2, 1'b1, 3, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 16'h7777, 255, 1'b0, 15, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, 16'hCAFE, 16'h0000, 200, 1'b1, 15, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 16'h0F0F, 14, 1'b0, 15, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 16'h1234, 15, 1'b1, 15, 1'b1};

    for (int i = 0; i < 11; i++) begin
      do_access(tbl[i].freq, tbl[i].dreq, tbl[i].dwe, tbl[i].fa, tbl[i].da,
                tbl[i].wd, tbl[i].rd, tbl[i].waits, 1'b0,
                tbl[i].exp_d, tbl[i].exp_cyc, tbl[i].exp_err);
    end

    // Reset in the second ACCESS cycle aborts without a Done pulse.
    FReq = 1'b1; FAddr = 16'h0ABC; DReq = 1'b0; MemReady = 1'b0;
    for (int c = 0; c < 8 && !FGnt; c++) begin
      @(posedge CLK); #1;
    end
    chk("rst_first_gnt", 32'(FGnt), 32'd1);
    @(posedge CLK); #1;
    chk("rst_second_gnt", 32'(FGnt), 32'd1);
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    FReq = 1'b0;
    chk("rst_abort_ctrl", 32'({FGnt, DGnt, FDone, DDone, MemRead, MemWrite}), 32'd0);
    chk("rst_abort_data", 32'({FRData, MemAddr}), 32'd0);
    m_frd = 16'h0; m_drd = 16'h0; m_last_f = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      chk("rst_no_done", 32'({FDone, DDone, FGnt}), 32'd0);
    end
    do_access(1'b1, 1'b0, 1'b0, 16'h0ABC, 16'h0, 16'h0, 16'hA5A5, 1, 1'b0, 1'b0, 2, 1'b0);

    // Randomized accesses against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      fq = 1'($urandom_range(0, 1));
      dq = 1'($urandom_range(0, 1));
      if (!fq && !dq) dq = 1'b1;
      we = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 3) == 0);
      w  = $urandom_range(0, 18);
      ed = dq && (!fq || (RR ? m_last_f : 1'b1));
      ecyc = (w < TO) ? w + 1 : TO;
      do_access(fq, dq, we, 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), w, de, ed, ecyc, (w >= TO));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
